mul_share_arbiter: RTL and testbench
====================================

Name: mul_share_arbiter

Overview:
Round-robin scheduler that shares one N-bit array multiplier and its registered product stage between two requesters. For each granted requester it captures the operands, drives the shared multiplier, and waits out the multiplier's fixed latency. It then returns the product with an acknowledge. It sits between the operand sources (keypad/PIPO front ends) and the single multiplier instance that feeds the hex display path.

Parameters:
N, 8, operand width; product width is 2*N.
MUL_LAT, 1, number of clock edges from the mul_a/mul_b update to a valid mul_p; legal range 0..7.

Ports:
clk  input  1  system clock, rising edge
clr  input  1  asynchronous reset, active-low
req0  input  1  requester 0 request, level
a0  input  N  requester 0 operand A
b0  input  N  requester 0 operand B
req1  input  1  requester 1 request, level
a1  input  N  requester 1 operand A
b1  input  N  requester 1 operand B
ack0  output  1  one-cycle completion pulse for requester 0
ack1  output  1  one-cycle completion pulse for requester 1
result  output  2*N  last completed product, held until the next completion
result_id  output  1  requester that owns result
done  output  1  one-cycle pulse, equals ack0|ack1
busy  output  1  high whenever state is not IDLE
mul_a  output  N  operand A to the shared multiplier, registered
mul_b  output  N  operand B to the shared multiplier, registered
mul_p  input  2*N  product from the shared multiplier

Behaviour:
- Reset (clr low, async): state IDLE; all outputs 0; round-robin pointer favours requester 0; latency counter 0.
- Handshake: a requester raises reqX and holds aX/bX stable until ackX. It must drop reqX in the cycle after ackX. A reqX still high in IDLE after that is a new request.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If no request, stay in IDLE.
  - If exactly one request is pending, grant it.
  - If both are pending, grant the requester that was not served last. After reset that is requester 0.
  - On the grant edge E: register the granted operands into mul_a/mul_b, record the grant id, load the counter with MUL_LAT, go to WAIT.
- WAIT:
  - Decrement the counter each edge while it is nonzero.
  - When it is 0, go to DONE on the next edge. That edge is E+MUL_LAT+1; on it, mul_p is sampled into result and result_id is set.
- DONE: lasts one cycle.
  - done=1, ackX=1 for the granted id, busy=1.
  - Flip the round-robin pointer to the other requester.
  - On the next edge return to IDLE.
  - No grant is made on this cycle.
- Latency: ack is high in the cycle following edge E+MUL_LAT+1. With MUL_LAT=1, ack follows the grant edge by 2 cycles. Minimum turnaround between grants is MUL_LAT+3 cycles.
- mul_a/mul_b hold their value after completion; they change only on a grant.
- A request that arrives or changes during WAIT/DONE is ignored until IDLE. Operand changes on the granted requester during WAIT are not observed (operands are captured at E).
- Reset mid-operation aborts the operation: no ack is issued, result returns to 0, and the pointer favours requester 0.
- Width: result is exactly the 2*N-bit mul_p, with no truncation or extension.

Optional Feature:
MUL_SHARE_ZERO_BYPASS_EN
- Defined: at the grant edge, if the granted A or B is 0, the FSM goes directly to DONE.
  - result is forced to 0 and the multiplier wait is skipped; ack follows edge E by one cycle.
  - mul_a/mul_b are still updated.
- Undefined: zero operands take the normal MUL_LAT path, and result is whatever mul_p returns.

Test Plan:
- Reset then single request: req0=1, a0=8'h0F, b0=8'h0E, MUL_LAT=1 with a registered multiplier model.
  - ack0 pulses 2 cycles after the grant edge; result=16'h00D2, result_id=0, ack1 stays 0.
- Simultaneous requests after reset: req0 with 8'h03×8'h05, req1 with 8'hFF×8'hFF, both raised together.
  - Requester 0 is served first: result=16'h000F, id 0.
  - Requester 1 is served next: result=16'hFE01, id 1; its grant comes 4 cycles after the first.
- Fairness: hold req0 and req1 high continuously, re-raising each after its ack.
  - Acks alternate 1,0,1,0 after the first pass; neither requester is served twice in a row.
- Request during busy: req1 is raised in the WAIT of a requester-0 op.
  - req1 is not granted before ack0; it is granted on the first IDLE edge after DONE.
- Reset mid-operation: pull clr low in WAIT.
  - All outputs are immediately 0 and no ack appears.
  - After release, with both requests pending, requester 0 wins.
- Zero operand: a0=8'h00, b0=8'h37.
  - Feature defined: ack0 one cycle after grant, result=0.
  - Feature undefined: ack0 after MUL_LAT+1 cycles, result=0.

Source files
------------

// File: rtl/mul_share_arbiter.sv
// Round-robin scheduler sharing one registered N-bit multiplier between two requesters.
// Optional MUL_SHARE_ZERO_BYPASS_EN: a zero operand completes without waiting on the multiplier.

module mul_share_arbiter #(
  parameter int unsigned N       = 8,
  parameter int unsigned MUL_LAT = 1
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           req0,
  input  logic [N-1:0]   a0,
  input  logic [N-1:0]   b0,
  input  logic           req1,
  input  logic [N-1:0]   a1,
  input  logic [N-1:0]   b1,
  output logic           ack0,
  output logic           ack1,
  output logic [2*N-1:0] result,
  output logic           result_id,
  output logic           done,
  output logic           busy,
  output logic [N-1:0]   mul_a,
  output logic [N-1:0]   mul_b,
  input  logic [2*N-1:0] mul_p
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e         state_q, state_d;
  logic [2:0]     cnt_q, cnt_d;
  logic           rr_q, rr_d;  // requester favoured when both are pending
  logic           id_q, id_d;
  logic [N-1:0]   mul_a_q, mul_a_d;
  logic [N-1:0]   mul_b_q, mul_b_d;
  logic [2*N-1:0] result_q, result_d;
  logic           result_id_q, result_id_d;

  logic           grant_id;
  logic [N-1:0]   grant_a;
  logic [N-1:0]   grant_b;

  always_comb begin
    grant_id = (req0 && req1) ? rr_q : req1;
    grant_a  = grant_id ? a1 : a0;
    grant_b  = grant_id ? b1 : b0;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_d        = rr_q;
    id_d        = id_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    result_d    = result_q;
    result_id_d = result_id_q;
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          id_d    = grant_id;
          mul_a_d = grant_a;
          mul_b_d = grant_b;
          cnt_d   = 3'(MUL_LAT);
          state_d = StWait;
`ifdef MUL_SHARE_ZERO_BYPASS_EN
          if (grant_a == '0 || grant_b == '0) begin
            state_d     = StDone;
            result_d    = '0;
            result_id_d = grant_id;
          end
`endif
        end
      end
      StWait: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          state_d     = StDone;
          result_d    = mul_p;
          result_id_d = id_q;
        end
      end
      StDone: begin
        rr_d    = ~id_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      rr_q        <= 1'b0;
      id_q        <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      result_q    <= '0;
      result_id_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      id_q        <= id_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      result_q    <= result_d;
      result_id_q <= result_id_d;
    end
  end

  assign ack0      = (state_q == StDone) && !id_q;
  assign ack1      = (state_q == StDone) && id_q;
  assign done      = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign result    = result_q;
  assign result_id = result_id_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: driver tasks push expected products per requester; a negedge
// monitor pops them on each ack and checks arbitration order, latency and hold behaviour.

module tb_mul_share_arbiter;

  localparam int N   = 8;
  localparam int LAT = 1;

  typedef struct packed {
    logic [2*N-1:0] prod;
    logic           zero;
  } exp_t;

  logic           clk = 1'b0;
  logic           clr;
  logic           req0, req1;
  logic [N-1:0]   a0, b0, a1, b1;
  logic           ack0, ack1, result_id, done, busy;
  logic [2*N-1:0] result;
  logic [N-1:0]   mul_a, mul_b;
  logic [2*N-1:0] mul_p = '0;

  exp_t q0[$];
  exp_t q1[$];

  int checks = 0;
  int errors = 0;
  bit end_chk = 1'b0;

  always #5 clk = ~clk;

  // Shared multiplier: one register stage, so mul_p is valid one edge after mul_a/mul_b.
  always @(posedge clk) mul_p <= {8'h00, mul_a} * {8'h00, mul_b};

  mul_share_arbiter #(.N(N), .MUL_LAT(LAT)) dut (
    .clk       (clk),
    .clr       (clr),
    .req0      (req0),
    .a0        (a0),
    .b0        (b0),
    .req1      (req1),
    .a1        (a1),
    .b1        (b1),
    .ack0      (ack0),
    .ack1      (ack1),
    .result    (result),
    .result_id (result_id),
    .done      (done),
    .busy      (busy),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p)
  );

  task automatic check(input bit ok, input string name, input string info);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", name, info);
    end
  endtask

  // ---------------- monitor / reference model ----------------
  initial begin : monitor
    int       cyc = 0;
    int       grant_cyc = 0;
    int       stall = 0;
    int       lat;
    bit       favour = 1'b0;
    bit       exp_id = 1'b0;
    bit       end_done = 1'b0;
    bit       grant_now, id;
    logic     p_clr = 1'b0, p_busy = 1'b0, p_req0 = 1'b0, p_req1 = 1'b0, p_rid = 1'b0;
    logic [N-1:0]   p_a0 = '0, p_b0 = '0, p_a1 = '0, p_b1 = '0, p_mul_a = '0, p_mul_b = '0;
    logic [N-1:0]   ea, eb;
    logic [2*N-1:0] p_result = '0;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!clr) begin
        check(!ack0 && !ack1 && !done && !busy && result == '0 && !result_id &&
              mul_a == '0 && mul_b == '0, "reset_zero",
              $sformatf("got ack=%b%b done=%b busy=%b result=%h id=%b mul=%h/%h, want all 0",
                        ack1, ack0, done, busy, result, result_id, mul_a, mul_b));
        favour = 1'b0;
        stall  = 0;
      end else begin
        grant_now = busy && !p_busy && p_clr;
        if (p_clr && !p_busy)
          check(busy == (p_req0 || p_req1), "grant_when_idle",
                $sformatf("got busy=%b, want %b (req=%b%b)", busy, p_req0 || p_req1,
                          p_req1, p_req0));
        if (grant_now) begin
          exp_id    = (p_req0 && p_req1) ? favour : p_req1;
          grant_cyc = cyc;
          ea = exp_id ? p_a1 : p_a0;
          eb = exp_id ? p_b1 : p_b0;
          check(mul_a == ea && mul_b == eb, "operand_capture",
                $sformatf("got %h/%h, want %h/%h (id %0d)", mul_a, mul_b, ea, eb, exp_id));
        end else if (p_clr) begin
          check(mul_a == p_mul_a && mul_b == p_mul_b, "mul_hold",
                $sformatf("got %h/%h, want %h/%h", mul_a, mul_b, p_mul_a, p_mul_b));
        end
        check(!(ack0 && ack1) && done == (ack0 || ack1) && (!done || busy), "ack_flags",
              $sformatf("got ack=%b%b done=%b busy=%b", ack1, ack0, done, busy));
        if (ack0 || ack1) begin
          id = ack1;
          check(id == exp_id, "ack_order", $sformatf("got id %0d, want %0d", id, exp_id));
          check(id ? q1.size() != 0 : q0.size() != 0, "ack_expected",
                $sformatf("got ack for id %0d, want no ack (nothing outstanding)", id));
          if (id ? q1.size() != 0 : q0.size() != 0) begin
            e = id ? q1.pop_front() : q0.pop_front();
            check(result == e.prod && result_id == id, "result",
                  $sformatf("got %h id %0d, want %h id %0d", result, result_id, e.prod, id));
            lat = LAT + 1;
`ifdef MUL_SHARE_ZERO_BYPASS_EN
            if (e.zero) lat = 0;
`endif
            check(cyc - grant_cyc == lat, "latency",
                  $sformatf("got %0d cycles, want %0d", cyc - grant_cyc, lat));
          end
          favour = !id;
        end else if (p_clr) begin
          check(result == p_result && result_id == p_rid, "result_hold",
                $sformatf("got %h id %0d, want %h id %0d", result, result_id, p_result, p_rid));
        end
        stall = (ack0 || ack1 || !(req0 || req1)) ? 0 : stall + 1;
        if (stall >= 50) begin
          check(ack0 || ack1, "ack_timeout", "got no ack for 50 cycles, want an ack");
          stall = 0;
        end
        if (end_chk && !end_done) begin
          check(q0.size() == 0 && q1.size() == 0, "queue_drain",
                $sformatf("got %0d/%0d outstanding, want 0/0", q0.size(), q1.size()));
          end_done = 1'b1;
        end
      end
      p_clr = clr; p_busy = busy; p_req0 = req0; p_req1 = req1;
      p_a0 = a0; p_b0 = b0; p_a1 = a1; p_b1 = b1;
      p_mul_a = mul_a; p_mul_b = mul_b; p_result = result; p_rid = result_id;
    end
  end

  // ---------------- stimulus ----------------
  function automatic exp_t mk_exp(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    e.prod = {8'h00, a} * {8'h00, b};
    e.zero = (a == '0) || (b == '0);
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 of the cycle in which req has been dropped.
  task automatic wait_ack_drop(input bit id);
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (id ? ack1 : ack0) break;
    end
    @(posedge clk);
    #1;
    if (id) req1 = 1'b0;
    else    req0 = 1'b0;
  endtask

  task automatic raise(input bit id, input logic [N-1:0] a, input logic [N-1:0] b);
    if (id) begin
      q1.push_back(mk_exp(a, b));
      a1 = a; b1 = b; req1 = 1'b1;
    end else begin
      q0.push_back(mk_exp(a, b));
      a0 = a; b0 = b; req0 = 1'b1;
    end
  endtask

  task automatic do_req(input bit id, input logic [N-1:0] a, input logic [N-1:0] b);
    raise(id, a, b);
    wait_ack_drop(id);
  endtask

  task automatic gap(input int n);
    repeat (n + 1) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 clr = 1'b0;
    gap(1);
    clr = 1'b1;
  endtask

  function automatic logic [N-1:0] rnd_op();
    return ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
  endfunction

  task automatic rand_loop(input bit id, input int iters, input int max_gap);
    for (int i = 0; i < iters; i++) begin
      gap($urandom_range(0, max_gap));
      do_req(id, rnd_op(), rnd_op());
    end
  endtask

  initial begin : driver
    clr = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (3) @(posedge clk);
    #1 clr = 1'b1;
    gap(1);

    do_req(1'b0, 8'h0F, 8'h0E);            // 0x00D2, two cycles after grant
    gap(2);

    pulse_reset();                          // simultaneous: requester 0 wins after reset
    fork
      do_req(1'b0, 8'h03, 8'h05);
      do_req(1'b1, 8'hFF, 8'hFF);
    join
    gap(2);

    fork                                    // fairness: both re-raise right after their ack
      rand_loop(1'b0, 4, 0);
      rand_loop(1'b1, 4, 0);
    join
    gap(2);

    fork                                    // req1 raised during requester 0's WAIT
      do_req(1'b0, 8'h21, 8'h13);
      begin
        gap(1);
        do_req(1'b1, 8'h44, 8'h05);
      end
    join
    gap(2);

    raise(1'b0, 8'h9A, 8'h0B);              // reset while requester 0 is in WAIT
    @(posedge clk);
    #3 clr = 1'b0;
    q0.delete();
    gap(1);
    q0.push_back(mk_exp(8'h9A, 8'h0B));
    raise(1'b1, 8'h12, 8'h34);
    gap(0);
    clr = 1'b1;
    fork
      wait_ack_drop(1'b0);
      wait_ack_drop(1'b1);
    join
    gap(2);

    do_req(1'b0, 8'h00, 8'h37);             // zero operand
    gap(2);

    fork
      rand_loop(1'b0, 20, 4);
      rand_loop(1'b1, 20, 4);
    join
    gap(4);

    end_chk = 1'b1;
    gap(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
